// File: rtl/round_key_scheduler.sv
// AES-128 key expansion: 44 words produced one per clock through a shared external S-box.
// All round keys are held in registers and exposed as a combinational column read.
module round_key_scheduler #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        key_we,
    input  logic [1:0]  key_idx,
    input  logic [31:0] key_word,
    input  logic        expand_start,
    output logic [31:0] sbox_in,
    input  logic [31:0] sbox_out,
    output logic        key_expand_done,
    input  logic [3:0]  rk_round,
    input  logic [1:0]  rk_col,
    output logic [31:0] rk_word,
    output logic [5:0]  dbg_word_idx
);
    localparam int NW = 4 * (NUM_ROUNDS + 1);

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [7:0]  rcon_q, rcon_d;
    logic [31:0] w_q [NW];
    logic [31:0] w_d [NW];

    logic [5:0]  word_sel;
    logic [31:0] prev_w, back_w, rot_w, temp_w;
    logic        is_rot;
    logic [5:0]  rd_addr;

    // Outside EXPAND the selector parks at 4 so the w[idx-1]/w[idx-4] reads stay in range.
    assign word_sel = (state_q == EXPAND) ? idx_q : 6'd4;
    assign prev_w   = w_q[word_sel - 6'd1];
    assign back_w   = w_q[word_sel - 6'd4];
    assign rot_w    = {prev_w[23:0], prev_w[31:24]};
    assign is_rot   = (word_sel[1:0] == 2'b00);
    assign temp_w   = is_rot ? (sbox_out ^ {rcon_q, 24'h0}) : prev_w;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (expand_start) state_d = EXPAND;
            EXPAND:  if (idx_q == 6'(NW - 1)) state_d = DONE;
            DONE: begin
                if (expand_start)  state_d = EXPAND;
                else if (key_we)   state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        key_expand_done = (state_q == DONE);
        dbg_word_idx    = '0;
        sbox_in         = '0;
        case (state_q)
            EXPAND: begin
                dbg_word_idx = idx_q;
                if (is_rot) sbox_in = rot_w;
            end
            DONE:    dbg_word_idx = 6'(NW);
            default: ;
        endcase
    end

    always_comb begin
        w_d    = w_q;
        idx_d  = idx_q;
        rcon_d = rcon_q;
        case (state_q)
            EXPAND: begin
                w_d[idx_q] = back_w ^ temp_w;
                idx_d      = idx_q + 6'd1;
                if (is_rot) rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
            end
            default: begin
                // Key loads are accepted in IDLE and DONE; a load in DONE makes the schedule stale.
                if (key_we) w_d[{4'd0, key_idx}] = key_word;
                if (expand_start) begin
                    idx_d  = 6'd4;
                    rcon_d = 8'h01;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx_q  <= '0;
            rcon_q <= 8'h01;
            for (int i = 0; i < NW; i++) w_q[i] <= '0;
        end else begin
            idx_q  <= idx_d;
            rcon_q <= rcon_d;
            for (int i = 0; i < NW; i++) w_q[i] <= w_d[i];
        end
    end

    assign rd_addr = {rk_round, 2'b00} + {4'd0, rk_col};
    assign rk_word = (rk_round > 4'(NUM_ROUNDS)) ? 32'h0 : w_q[rd_addr];

endmodule

// File: tb/tb_round_key_scheduler.sv
// Bench for round_key_scheduler: a reference key-schedule model plus FIPS-197 literals.
module tb_round_key_scheduler;
    logic        clock = 1'b0, reset_n = 1'b0;
    logic        key_we = 1'b0, expand_start = 1'b0;
    logic [1:0]  key_idx = '0, rk_col = '0;
    logic [31:0] key_word = '0;
    logic [3:0]  rk_round = '0;
    logic [31:0] sbox_in, sbox_out, rk_word;
    logic        key_expand_done;
    logic [5:0]  dbg_word_idx;

    int checks = 0, failures = 0;
    bit cmp_en = 1'b0;

    always #5 clock = ~clock;

    round_key_scheduler #(.NUM_ROUNDS(10)) dut (
        .clock(clock), .reset_n(reset_n), .key_we(key_we), .key_idx(key_idx),
        .key_word(key_word), .expand_start(expand_start), .sbox_in(sbox_in),
        .sbox_out(sbox_out), .key_expand_done(key_expand_done), .rk_round(rk_round),
        .rk_col(rk_col), .rk_word(rk_word), .dbg_word_idx(dbg_word_idx)
    );

    // S-box from first principles: GF(2^8) inverse followed by the affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sb(input logic [7:0] a);
        logic [7:0] inv = '0;
        for (int x = 1; x < 256; x++) if (gmul(a, 8'(x)) == 8'h01) inv = 8'(x);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sw(input logic [31:0] w);
        return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
    endfunction

    assign sbox_out = sw(sbox_in);

    localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    // Model: full schedule of the held key, revealed one word per cycle while expanding.
    logic [31:0] m_w [44];
    logic [31:0] m_full [44];
    logic [31:0] m_t;
    int m_mode, m_idx;   // mode 0 idle, 1 expanding, 2 done

    always_comb begin
        m_t = '0;
        for (int i = 0; i < 4; i++) m_full[i] = m_w[i];
        for (int i = 4; i < 44; i++) begin
            m_t = m_full[i-1];
            if (i % 4 == 0) m_t = sw({m_t[23:0], m_t[31:24]}) ^ {RCON[i/4-1], 24'h0};
            m_full[i] = m_full[i-4] ^ m_t;
        end
    end

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_mode <= 0;
            m_idx  <= 0;
            for (int i = 0; i < 44; i++) m_w[i] <= '0;
        end else if (m_mode == 1) begin
            m_w[m_idx] <= m_full[m_idx];
            m_idx      <= m_idx + 1;
            if (m_idx == 43) m_mode <= 2;
        end else begin
            if (key_we) m_w[key_idx] <= key_word;
            if (expand_start) begin
                m_mode <= 1;
                m_idx  <= 4;
            end else if (key_we && m_mode == 2) m_mode <= 0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (cmp_en) begin
            logic [31:0] e_sb, e_rk;
            logic [5:0]  e_dbg;
            e_sb  = '0;
            e_dbg = (m_mode == 1) ? 6'(m_idx) : ((m_mode == 2) ? 6'd44 : 6'd0);
            if (m_mode == 1 && m_idx >= 4 && m_idx % 4 == 0)
                e_sb = {m_full[m_idx-1][23:0], m_full[m_idx-1][31:24]};
            e_rk = (rk_round > 4'd10) ? 32'h0 : m_w[4*rk_round + rk_col];
            chk("cyc_done", {31'd0, key_expand_done}, {31'd0, m_mode == 2});
            chk("cyc_dbg", {26'd0, dbg_word_idx}, {26'd0, e_dbg});
            chk("cyc_sbox_in", sbox_in, e_sb);
            chk("cyc_rk_word", rk_word, e_rk);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input int c, input logic [31:0] v);
        key_we = 1'b1; key_idx = 2'(c); key_word = v;
        tick();
        key_we = 1'b0;
    endtask

    task automatic rd(input int r, input int c, output logic [31:0] v);
        rk_round = 4'(r); rk_col = 2'(c);
        @(negedge clock);
        v = rk_word;
        tick();
    endtask

    // Pulses expand_start and follows the run to done, capturing S-box traffic on the way.
    task automatic run(input bit inject, output int lat, output logic [31:0] s4,
                       output logic [31:0] s36, output logic [31:0] s40,
                       output logic [31:0] si4, output logic [31:0] si57);
        expand_start = 1'b1;
        tick();
        expand_start = 1'b0; key_we = 1'b0;
        lat = -1; s4 = '0; s36 = '0; s40 = '0; si4 = '0; si57 = '0;
        for (int e = 0; e < 60; e++) begin
            @(negedge clock);
            if (dbg_word_idx == 6'd4)  begin s4 = sbox_out; si4 = sbox_in; end
            if (dbg_word_idx >= 6'd5 && dbg_word_idx <= 6'd7) si57 = si57 | sbox_in;
            if (dbg_word_idx == 6'd36) s36 = sbox_out;
            if (dbg_word_idx == 6'd40) s40 = sbox_out;
            if (key_expand_done) begin lat = e; break; end
            if (inject && e == 6) begin #1; key_we = 1'b1; key_idx = 2'd0; key_word = '1; expand_start = 1'b1; end
            if (inject && e == 7) begin #1; key_we = 1'b0; expand_start = 1'b0; end
        end
        tick();
    endtask

    task automatic check_keys(input string tag, input int lat, input logic [31:0] s4,
                              input logic [31:0] s36, input logic [31:0] s40);
        logic [31:0] v, a, b;
        logic [31:0] r1 [4]  = '{32'ha0fafe17, 32'h88542cb1, 32'h23a33939, 32'h2a6c7605};
        logic [31:0] r10 [4] = '{32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6};
        chk({tag, "_latency"}, 32'(lat), 32'd40);
        for (int c = 0; c < 4; c++) begin
            rd(1, c, v);  chk({tag, "_round1"}, v, r1[c]);
            rd(10, c, v); chk({tag, "_round10"}, v, r10[c]);
        end
        rd(0, 0, a); rd(1, 0, b);
        chk({tag, "_rcon_w4"}, {24'd0, (a ^ b ^ s4) >> 24}, 32'h01);
        rd(8, 0, a); rd(9, 0, b);
        chk({tag, "_rcon_w36"}, {24'd0, (a ^ b ^ s36) >> 24}, 32'h1b);
        rd(10, 0, a);
        chk({tag, "_rcon_w40"}, {24'd0, (a ^ b ^ s40) >> 24}, 32'h36);
        rd(11, 0, v); chk({tag, "_rk_round11"}, v, 32'h0);
        rd(15, 3, v); chk({tag, "_rk_round15"}, v, 32'h0);
    endtask

    initial begin
        int lat;
        bit found;
        logic [31:0] s4, s36, s40, si4, si57;

        repeat (3) tick();
        reset_n = 1'b1;
        cmp_en  = 1'b1;
        chk("rst_done", {31'd0, key_expand_done}, 32'd0);
        chk("rst_dbg", {26'd0, dbg_word_idx}, 32'd0);
        chk("rst_sbox_in", sbox_in, 32'h0);
        chk("sbox_pin_53", {24'd0, sb(8'h53)}, 32'h000000ed);

        load(0, 32'h2b7e1516);
        load(1, 32'h28aed2a6);
        load(2, 32'habf71588);
        // Last column written in the same cycle as the start pulse.
        key_we = 1'b1; key_idx = 2'd3; key_word = 32'h09cf4f3c;
        run(1'b0, lat, s4, s36, s40, si4, si57);
        chk("model_w4", m_full[4], 32'ha0fafe17);
        chk("model_w43", m_full[43], 32'hb6630ca6);
        chk("run1_sbox_in_idx4", si4, 32'hcf4f3c09);
        chk("run1_sbox_in_idx5_7", si57, 32'h0);
        check_keys("run1", lat, s4, s36, s40);

        // Back-to-back rerun from DONE with a stray load and start pulse mid-expansion.
        run(1'b1, lat, s4, s36, s40, si4, si57);
        chk("run2_sbox_in_idx4", si4, 32'hcf4f3c09);
        check_keys("run2", lat, s4, s36, s40);

        load(0, 32'h2b7e1516);
        chk("done_kwe_done", {31'd0, key_expand_done}, 32'd0);
        chk("done_kwe_dbg", {26'd0, dbg_word_idx}, 32'd0);

        expand_start = 1'b1;
        tick();
        expand_start = 1'b0;
        found = 1'b0;
        for (int e = 0; e < 60; e++) begin
            @(negedge clock);
            if (dbg_word_idx == 6'd20) begin found = 1'b1; break; end
        end
        chk("reach_idx20", {31'd0, found}, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_done", {31'd0, key_expand_done}, 32'd0);
        chk("midrst_dbg", {26'd0, dbg_word_idx}, 32'd0);
        tick();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 4; c++) begin
                logic [31:0] v;
                rd(r, c, v);
                chk("midrst_rk_zero", v, 32'h0);
            end
        reset_n = 1'b1;
        repeat (2) tick();
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/round_key_scheduler.md
Name: round_key_scheduler

Overview:
- Sequences AES-128 key expansion: accepts the 128-bit cipher key as four 32-bit columns and generates all 44 round-key words, one word per clock.
- Time-shares one external 4-byte S-box (SubWord) lookup.
- Stores the 11 round keys and serves column reads to the round datapath.
- Asserts key_expand_done, which the encryption state manager waits on in COMPUTE_ROUNDKEYS.

Parameters:
- NUM_ROUNDS, 10, number of AES rounds. Only 10 (AES-128) is supported. Storage is 4*(NUM_ROUNDS+1) words.

Ports:
- clock  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- key_we  input  1  write one cipher-key column this cycle
- key_idx  input  2  column index for key_we (0..3)
- key_word  input  32  key column; [31:24] is the first key byte of the column
- expand_start  input  1  single-cycle pulse that begins expansion
- sbox_in  output  32  four bytes to the shared S-box
- sbox_out  input  32  combinational S-box result, byte-wise for sbox_in
- key_expand_done  output  1  level; all round keys valid
- rk_round  input  4  round-key read select (0..10)
- rk_col  input  2  round-key column select
- rk_word  output  32  combinational read: w[4*rk_round+rk_col]
- dbg_word_idx  output  6  current expansion word index

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (ports clock, reset_n).
- Reset values: state IDLE, key_expand_done=0, dbg_word_idx=0, rcon=8'h01, sbox_in=0. All 44 storage words clear to 0.
- States:
  - IDLE:
    - key_we writes w[key_idx] on the clock edge.
    - expand_start -> EXPAND, with idx=4 and rcon=01.
  - EXPAND: each cycle writes w[idx]=w[idx-4]^t, with t selected by idx:
    - idx%4==0: t = sbox_out ^ {rcon,24'h0}, and sbox_in = RotWord(w[idx-1]) = {w[idx-1][23:0], w[idx-1][31:24]}. After that write, rcon advances via xtime: 01,02,04,08,10,20,40,80,1b,36.
    - otherwise: t = w[idx-1], and sbox_in = 0.
    - idx increments each cycle. On writing idx=43 -> DONE.
  - DONE:
    - key_expand_done=1.
    - key_we writes the column, clears done and goes to IDLE (the key is stale).
    - expand_start re-runs EXPAND from idx=4. done drops the cycle after the pulse.
- Latency: with expand_start sampled at edge N, done is high after edge N+40, i.e. 40 EXPAND cycles.
- key_we during EXPAND is ignored (no write). expand_start during EXPAND is ignored.
- key_we and expand_start in the same IDLE cycle: the write lands and expansion starts next cycle using the new column.
- dbg_word_idx equals idx in EXPAND, 0 in IDLE and 44 in DONE.
- rk_word is a purely combinational read and valid in any state. Contents are only meaningful while key_expand_done=1 (words 0..3 are meaningful once written). rk_round>10 returns 32'h0.
- reset_n low mid-expansion: immediate return to IDLE, done=0, storage cleared. A fresh key load is required.

Test Plan:
- FIPS-197 key: write 2b7e1516, 28aed2a6, abf71588, 09cf4f3c to idx 0..3, pulse expand_start -> done high exactly 40 cycles later. Round 1 = a0fafe17 88542cb1 23a33939 2a6c7605. Round 10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
- S-box sharing: during that run -> sbox_in = cf4f3c09 at idx=4, and sbox_in=0 at idx=5..7.
- Rcon wrap: check the rcon applied at idx=36 is 1b and at idx=40 is 36. Run the expansion twice back-to-back from DONE -> identical round 10 and rcon restarted at 01.
- Interference: key_we (idx 0, ffffffff) and expand_start pulsed mid-EXPAND -> ignored, results unchanged. Then key_we in DONE -> done=0 and state IDLE.
- Reset at idx=20 -> done=0, dbg_word_idx=0, rk_word=0 for all addresses. rk_round=11 always reads 0.
